// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared types and constants for the 4x4 keypad scanner:
//                scanner state encoding, idle/initial drive patterns and
//                row/column helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam int KEY_CODE_W = 4;

    // Column drive after reset: column 0 pulled low, others released.
    localparam logic [3:0] COL_INIT  = 4'b1110;
    // Row pattern seen when no key closes a circuit.
    localparam logic [3:0] ROWS_IDLE = 4'hF;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } scan_state_t;

    // Index of the lowest-numbered row that reads low (0 when none is low).
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Index of the column currently driven low in a one-hot-low pattern.
    function automatic logic [1:0] driven_col(input logic [3:0] cols);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!cols[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : scan_tick_gen
//  Description : Free-running divider that emits a one-cycle scan tick every
//                CLK_DIV clock cycles. The first tick arrives CLK_DIV cycles
//                after reset is released.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_tick_gen #(
    parameter int CLK_DIV = 12500
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int                 c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    logic [c_DIV_W-1:0] r_div;

    // Count 0..CLK_DIV-1 and wrap; the tick is the terminal-count cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
        end else if (r_div == c_DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_DIV_W'(1);
        end
    end

    assign tick = (r_div == c_DIV_LAST);

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : 4x4 matrix keypad front end. Walks a low level across the
//                columns, synchronises the rows, debounces press and release
//                and reports one raw scan code per physical press together
//                with a modulo-8 press counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_DIV        = 12500,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            row,
    output logic [3:0]            col,
    input  logic                  count_clr,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    output logic                  key_down,
    output logic [2:0]            key_count
);

    localparam logic [3:0] c_DEB_TICKS = 4'(DEBOUNCE_TICKS);

    logic                  w_tick;
    logic [3:0]            r_row_meta;
    logic [3:0]            r_row_sync;
    scan_state_t           r_state;
    scan_state_t           w_state_nxt;
    logic [3:0]            r_col;
    logic [3:0]            w_col_nxt;
    logic [3:0]            w_col_rot;
    logic [1:0]            r_row_idx;
    logic [1:0]            w_row_idx_nxt;
    logic [1:0]            w_row_low;
    logic [3:0]            r_dcnt;
    logic [3:0]            w_dcnt_nxt;
    logic [3:0]            w_dcnt_inc;
    logic                  w_accept;
    logic [KEY_CODE_W-1:0] w_accept_code;
    logic [KEY_CODE_W-1:0] r_key_code;
    logic                  r_key_valid;
    logic [2:0]            r_key_count;

    scan_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign w_col_rot  = {r_col[2:0], r_col[3]};
    assign w_row_low  = lowest_low_row(r_row_sync);
    assign w_dcnt_inc = r_dcnt + 4'd1;

    // Two-flop synchroniser for the asynchronous row lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_meta <= ROWS_IDLE;
            r_row_sync <= ROWS_IDLE;
        end else begin
            r_row_meta <= row;
            r_row_sync <= r_row_meta;
        end
    end

    // Scanner state, column drive, latched row and debounce counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= SCAN;
            r_col     <= COL_INIT;
            r_row_idx <= 2'd0;
            r_dcnt    <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_col     <= w_col_nxt;
            r_row_idx <= w_row_idx_nxt;
            r_dcnt    <= w_dcnt_nxt;
        end
    end

    // Next-state decisions; nothing moves except on a scan tick.
    always_comb begin
        w_state_nxt   = r_state;
        w_col_nxt     = r_col;
        w_row_idx_nxt = r_row_idx;
        w_dcnt_nxt    = r_dcnt;
        w_accept      = 1'b0;
        w_accept_code = {r_row_idx, driven_col(r_col)};
        if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (r_row_sync != ROWS_IDLE) begin
                        w_row_idx_nxt = w_row_low;
                        w_dcnt_nxt    = 4'd1;
                        if (c_DEB_TICKS == 4'd1) begin
                            w_accept      = 1'b1;
                            w_accept_code = {w_row_low, driven_col(r_col)};
                            w_state_nxt   = HELD;
                        end else begin
                            w_state_nxt = DEB_PRESS;
                        end
                    end else begin
                        w_col_nxt = w_col_rot;
                    end
                end
                DEB_PRESS: begin
                    if (!r_row_sync[r_row_idx]) begin
                        w_dcnt_nxt = w_dcnt_inc;
                        if (w_dcnt_inc == c_DEB_TICKS) begin
                            w_accept    = 1'b1;
                            w_state_nxt = HELD;
                        end
                    end else begin
                        w_state_nxt = SCAN;
                        w_col_nxt   = w_col_rot;
                    end
                end
                HELD: begin
                    if (r_row_sync == ROWS_IDLE) begin
                        w_dcnt_nxt = 4'd1;
                        // A single-sample debounce completes the release at once.
                        if (c_DEB_TICKS == 4'd1) begin
                            w_state_nxt = SCAN;
                            w_col_nxt   = w_col_rot;
                        end else begin
                            w_state_nxt = DEB_REL;
                        end
                    end
                end
                DEB_REL: begin
                    if (r_row_sync == ROWS_IDLE) begin
                        w_dcnt_nxt = w_dcnt_inc;
                        if (w_dcnt_inc == c_DEB_TICKS) begin
                            w_state_nxt = SCAN;
                            w_col_nxt   = w_col_rot;
                        end
                    end else begin
                        w_state_nxt = HELD;
                    end
                end
                default: begin
                    w_state_nxt = SCAN;
                end
            endcase
        end
    end

    // Registered key event outputs; a clear outranks the press increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_count <= 3'd0;
        end else begin
            r_key_valid <= w_accept;
            if (w_accept) begin
                r_key_code <= w_accept_code;
            end
            if (count_clr) begin
                r_key_count <= 3'd0;
            end else if (w_accept) begin
                r_key_count <= r_key_count + 3'd1;
            end
        end
    end

    assign col       = r_col;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_count = r_key_count;
    assign key_down  = (r_state == HELD) || (r_state == DEB_REL);

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Self-checking bench for keypad_scanner. A physical keypad
//                model closes row/column contacts; a press/release reference
//                model predicts every output on every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int CLK_DIV = 4;
    localparam int DEB     = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       count_clr;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic [2:0] key_count;

    int n_vec = 0;
    int n_err = 0;
    int dut_pulses = 0;

    // Physical keypad: pressed[r*4+c]; forced_low pulls rows low regardless of column.
    bit         pressed [16];
    logic [3:0] forced_low;

    // Reference model: scanning column, candidate key, run lengths of samples.
    int         m_col;
    int         m_cand;
    int         m_run;
    int         m_rel_run;
    bit         m_held;
    bit         m_valid;
    int         m_code;
    int         m_count;
    int         m_cyc;
    logic [3:0] m_meta;
    logic [3:0] m_rs;

    keypad_scanner #(
        .CLK_DIV        (CLK_DIV),
        .DEBOUNCE_TICKS (DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .count_clr (count_clr),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down),
        .key_count (key_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] keypad_rows();
        logic [3:0] rows;
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (pressed[r*4 + m_col]) rows[r] = 1'b0;
        end
        return rows & ~forced_low;
    endfunction

    task automatic model_reset();
        m_col = 0; m_cand = -1; m_run = 0; m_rel_run = 0; m_held = 0;
        m_valid = 0; m_code = 0; m_count = 0; m_cyc = 0;
        m_meta = 4'hF; m_rs = 4'hF;
    endtask

    task automatic model_accept(input int r);
        m_held    = 1;
        m_rel_run = 0;
        m_valid   = 1;
        m_code    = r * 4 + m_col;
    endtask

    // Apply one clock edge's worth of behaviour using the inputs just sampled.
    task automatic model_edge();
        logic [3:0] rs;
        bit         tick;
        int         low;
        if (rst) begin
            model_reset();
            return;
        end
        rs     = m_rs;
        m_rs   = m_meta;
        m_meta = row;
        tick   = (m_cyc % CLK_DIV) == (CLK_DIV - 1);
        m_cyc++;
        m_valid = 0;
        if (tick) begin
            if (!m_held && m_cand < 0) begin
                if (rs != 4'hF) begin
                    low = 0;
                    while (rs[low]) low++;
                    m_cand = low;
                    m_run  = 1;
                    if (m_run == DEB) begin model_accept(m_cand); m_cand = -1; end
                end else begin
                    m_col = (m_col + 1) % 4;
                end
            end else if (!m_held) begin
                if (!rs[m_cand]) begin
                    m_run++;
                    if (m_run == DEB) begin model_accept(m_cand); m_cand = -1; end
                end else begin
                    m_cand = -1;
                    m_col  = (m_col + 1) % 4;
                end
            end else if (rs == 4'hF) begin
                m_rel_run++;
                if (m_rel_run == DEB) begin
                    m_held    = 0;
                    m_rel_run = 0;
                    m_col     = (m_col + 1) % 4;
                end
            end else begin
                m_rel_run = 0;
            end
        end
        if (count_clr)    m_count = 0;
        else if (m_valid) m_count = (m_count + 1) % 8;
    endtask

    task automatic compare_all();
        logic [3:0] exp_col;
        exp_col = 4'hF ^ (4'(1) << m_col);
        if (key_valid === 1'b1) dut_pulses++;
        chk_val("col",       32'(col),       32'(exp_col));
        chk_val("key_code",  32'(key_code),  32'(m_code));
        chk_val("key_valid", 32'(key_valid), 32'(m_valid));
        chk_val("key_down",  32'(key_down),  32'(m_held));
        chk_val("key_count", 32'(key_count), 32'(m_count));
    endtask

    task automatic step();
        row = keypad_rows();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic release_all();
        for (int k = 0; k < 16; k++) pressed[k] = 0;
        forced_low = 4'h0;
    endtask

    task automatic press(input int r, input int c, input int hold, input int gap);
        pressed[r*4 + c] = 1;
        run(hold);
        release_all();
        run(gap);
    endtask

    int p0;
    int waited;

    initial begin
        rst        = 1'b1;
        count_clr  = 1'b0;
        row        = 4'hF;
        release_all();
        model_reset();
        @(negedge clk);

        // Reset held for three cycles, then idle scanning.
        run(3);
        chk_val("rst_col",   32'(col),       32'h0000000E);
        chk_val("rst_count", 32'(key_count), 32'd0);
        rst = 1'b0;
        run(20);

        // Clean press of row 1 / column 2 held for ten ticks.
        p0 = dut_pulses;
        press(1, 2, 40, 40);
        chk_val("clean_pulses", 32'(dut_pulses - p0), 32'd1);
        chk_val("clean_code",   32'(key_code),        32'd6);
        chk_val("clean_count",  32'(key_count),       32'd1);

        // Row 0 low for only two ticks: rejected as bounce.
        p0 = dut_pulses;
        forced_low = 4'b0001;
        run(8);
        release_all();
        run(30);
        chk_val("bounce_pulses", 32'(dut_pulses - p0), 32'd0);
        chk_val("bounce_count",  32'(key_count),       32'd1);

        // Release bounce while held, then a full release and a re-press.
        p0 = dut_pulses;
        pressed[2*4 + 3] = 1;
        run(50);
        pressed[2*4 + 3] = 0;
        run(4);
        pressed[2*4 + 3] = 1;
        run(30);
        chk_val("relbounce_down",   32'(key_down),        32'd1);
        pressed[2*4 + 3] = 0;
        run(40);
        chk_val("relbounce_pulses", 32'(dut_pulses - p0), 32'd1);
        press(0, 1, 50, 40);
        chk_val("repress_count", 32'(key_count), 32'd3);

        // Two rows low on column 0: lowest row wins.
        pressed[1*4 + 0] = 1;
        pressed[3*4 + 0] = 1;
        run(50);
        release_all();
        run(40);
        chk_val("multirow_code", 32'(key_code), 32'd4);

        // Four more presses bring the total to eight: counter wraps.
        for (int i = 0; i < 4; i++) press(i, 3 - i, 50, 40);
        chk_val("wrap_count", 32'(key_count), 32'd0);

        // Clear held across the accept: count stays zero, event still reported.
        p0 = dut_pulses;
        count_clr = 1'b1;
        press(2, 1, 50, 0);
        count_clr = 1'b0;
        run(40);
        chk_val("clr_pulses", 32'(dut_pulses - p0), 32'd1);
        chk_val("clr_code",   32'(key_code),        32'd9);
        chk_val("clr_count",  32'(key_count),       32'd0);

        // Reset while a press is being debounced.
        pressed[1*4 + 1] = 1;
        waited = 0;
        while (!(m_cand >= 0 && !m_held) && waited < 200) begin
            step();
            waited++;
        end
        chk_val("deb_press_reached", 32'(waited < 200), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_val("midrst_col",  32'(col),      32'h0000000E);
        chk_val("midrst_code", 32'(key_code), 32'd0);
        release_all();
        p0 = dut_pulses;
        run(40);
        chk_val("midrst_pulses", 32'(dut_pulses - p0), 32'd0);

        // Randomised presses, chords, bounces, clears and occasional resets.
        for (int i = 0; i < 60; i++) begin
            pressed[$urandom_range(0, 15)] = 1;
            if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, 15)] = 1;
            count_clr = ($urandom_range(0, 7) == 0);
            run($urandom_range(0, 60));
            count_clr = 1'b0;
            release_all();
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            run($urandom_range(0, 50));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
